// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory write-type codes, store-buffer drain states and entry layout.
package cpu_pkg;

    localparam int CPU_ADDR_W = 32;
    localparam int CPU_DATA_W = 32;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic [1:0] {
        SCB_IDLE = 2'd0,
        SCB_REQ  = 2'd1,
        SCB_WAIT = 2'd2
    } scb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [CPU_ADDR_W-1:0] addr;
        logic [CPU_DATA_W-1:0] data;
        logic [1:0]            mtype;
    } scb_entry_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/store_commit_buffer_if.sv
// Bundle of the commit, memory-write and load-check signals around the store commit buffer.
interface store_commit_buffer_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int PTR_W  = 2
);
    logic              commit_valid;
    logic              commit_ready;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;
    logic [1:0]        commit_type;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [1:0]        mem_type;
    logic              mem_done;
    logic [ADDR_W-1:0] load_addr;
    logic              load_conflict;
    logic              fwd_valid;
    logic [DATA_W-1:0] fwd_data;
    logic              empty;
    logic [PTR_W:0]    count;

    modport master (
        output commit_valid, commit_addr, commit_data, commit_type, mem_done, load_addr,
        input  commit_ready, mem_req, mem_addr, mem_data, mem_type,
        input  load_conflict, fwd_valid, fwd_data, empty, count
    );

    modport slave (
        input  commit_valid, commit_addr, commit_data, commit_type, mem_done, load_addr,
        output commit_ready, mem_req, mem_addr, mem_data, mem_type,
        output load_conflict, fwd_valid, fwd_data, empty, count
    );
endinterface

// File: rtl/store_match_cam.sv
// Word-address comparator across all buffer entries; reports the youngest matching entry.
module store_match_cam #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int TAG_W = 30
) (
    input  logic [PTR_W-1:0]             head,
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][TAG_W-1:0]  tags,
    input  logic [TAG_W-1:0]             probe,
    output logic                         hit,
    output logic [PTR_W-1:0]             hit_idx
);
    logic [PTR_W-1:0] idx_s;

    // Walk from oldest (head) to youngest so the last match found wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = head;
        idx_s   = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head + PTR_W'(i);
            if (valid[idx_s] && (tags[idx_s] == probe)) begin
                hit     = 1'b1;
                hit_idx = idx_s;
            end else begin
                hit     = hit;
                hit_idx = hit_idx;
            end
        end
    end
endmodule

// File: rtl/store_commit_buffer.sv
// FIFO of committed stores draining in order to data memory, one outstanding write at a time.
// Define STORE_FWD_EN to forward a youngest full-word store directly to a matching load.
module store_commit_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int PTR_W  = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    store_commit_buffer_if.slave bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ZERO_CNT = {(PTR_W+1){1'b0}};
    localparam int             TAG_W    = ADDR_W - 2;

    scb_entry_t                  entry_r [DEPTH];
    logic [PTR_W-1:0]            head_r;
    logic [PTR_W-1:0]            tail_r;
    logic [PTR_W:0]              count_r;
    scb_state_e                  state_r;
    scb_state_e                  next_state_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        capture_s;
    logic                        mem_req_nxt_s;
    logic                        mem_req_r;
    logic [ADDR_W-1:0]           mem_addr_r;
    logic [DATA_W-1:0]           mem_data_r;
    logic [1:0]                  mem_type_r;
    logic [DEPTH-1:0]            valid_s;
    logic [DEPTH-1:0][TAG_W-1:0] tag_s;
    logic                        hit_s;
    logic [PTR_W-1:0]            hit_idx_s;
    logic                        unused_s;

    // Drain FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= SCB_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Drain FSM next state; a done seen in REQ completes the write immediately
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            SCB_IDLE: begin
                if (count_r != ZERO_CNT) next_state_s = SCB_REQ;
                else                     next_state_s = SCB_IDLE;
            end
            SCB_REQ: begin
                if (bus.mem_done) next_state_s = SCB_IDLE;
                else              next_state_s = SCB_WAIT;
            end
            SCB_WAIT: begin
                if (bus.mem_done) next_state_s = SCB_IDLE;
                else              next_state_s = SCB_WAIT;
            end
            default: next_state_s = SCB_IDLE;
        endcase
    end

    // Drain FSM outputs: push acceptance, head capture and pop strobes
    always_comb begin
        push_s    = bus.commit_valid && (count_r != FULL_CNT);
        pop_s     = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            SCB_IDLE: begin
                capture_s = (next_state_s == SCB_REQ);
                pop_s     = 1'b0;
            end
            SCB_REQ, SCB_WAIT: begin
                capture_s = 1'b0;
                pop_s     = bus.mem_done;
            end
            default: begin
                capture_s = 1'b0;
                pop_s     = 1'b0;
            end
        endcase
        mem_req_nxt_s = (next_state_s != SCB_IDLE);
    end

    // Pointer and occupancy tracking; a pop never targets the slot being pushed
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= ZERO_CNT;
        end else begin
            if (push_s) tail_r <= tail_r + PTR_W'(1);
            if (pop_s)  head_r <= head_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage: fill at tail, invalidate head when its write completes
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) entry_r[i] <= '0;
        end else begin
            if (push_s) begin
                entry_r[tail_r] <= '{valid: 1'b1, addr: bus.commit_addr,
                                     data: bus.commit_data, mtype: bus.commit_type};
            end
            if (pop_s) entry_r[head_r].valid <= 1'b0;
        end
    end

    // Registered memory request; mem_* held stable for the whole write
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_data_r <= {DATA_W{1'b0}};
            mem_type_r <= 2'd0;
        end else begin
            mem_req_r <= mem_req_nxt_s;
            if (capture_s) begin
                mem_addr_r <= entry_r[head_r].addr;
                mem_data_r <= entry_r[head_r].data;
                mem_type_r <= entry_r[head_r].mtype;
            end
        end
    end

    // Gather per-entry word tags for the load check
    always_comb begin
        valid_s = {DEPTH{1'b0}};
        tag_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_s[i] = entry_r[i].valid;
            tag_s[i]   = entry_r[i].addr[ADDR_W-1:2];
        end
    end

    store_match_cam #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .TAG_W (TAG_W)
    ) u_cam (
        .head    (head_r),
        .valid   (valid_s),
        .tags    (tag_s),
        .probe   (bus.load_addr[ADDR_W-1:2]),
        .hit     (hit_s),
        .hit_idx (hit_idx_s)
    );

`ifdef STORE_FWD_EN
    scb_entry_t hit_entry_s;

    // Forward only when the youngest match is an aligned word store at exactly load_addr
    always_comb begin
        hit_entry_s = entry_r[hit_idx_s];
        if (hit_s && hit_entry_s.valid && (hit_entry_s.mtype == MEM_WORD) &&
            (hit_entry_s.addr == bus.load_addr) && word_aligned(hit_entry_s.addr[1:0])) begin
            bus.fwd_valid     = 1'b1;
            bus.fwd_data      = hit_entry_s.data;
            bus.load_conflict = 1'b0;
        end else begin
            bus.fwd_valid     = 1'b0;
            bus.fwd_data      = {DATA_W{1'b0}};
            bus.load_conflict = hit_s;
        end
    end
`else
    assign bus.fwd_valid     = 1'b0;
    assign bus.fwd_data      = {DATA_W{1'b0}};
    assign bus.load_conflict = hit_s;
`endif

    assign unused_s = ^{hit_idx_s, bus.load_addr[1:0]};

    assign bus.commit_ready = (count_r != FULL_CNT);
    assign bus.empty        = (count_r == ZERO_CNT) && (state_r == SCB_IDLE);
    assign bus.count        = count_r;
    assign bus.mem_req      = mem_req_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_data     = mem_data_r;
    assign bus.mem_type     = mem_type_r;
endmodule
